// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl
//   Single-clock FIFO with a first-word-fall-through read port, occupancy
//   count, almost-full/almost-empty thresholds, a synchronous flush and
//   sticky overflow/underflow flags.
//
// Parameters
//   WIDTH    data word width
//   DEPTH    log2 of entry count (entries = 1 << DEPTH), >= 1
//   AF_LEVEL almost_full_o  when count_o >= AF_LEVEL (1 .. 1<<DEPTH)
//   AE_LEVEL almost_empty_o when count_o <= AE_LEVEL (0 .. (1<<DEPTH)-1)
//
// Ports
//   clk            clock, rising edge
//   rst_ni         asynchronous active-low reset
//   clr_i          synchronous flush, overrides push/pop
//   push_i, dat_i  write request and data
//   full_o         no free entry
//   almost_full_o  count_o >= AF_LEVEL
//   pop_i          read request, acknowledges current dat_o
//   dat_o          head-of-queue data, zero while empty
//   empty_o        no stored entry
//   almost_empty_o count_o <= AE_LEVEL
//   count_o        stored entries, 0 .. 1<<DEPTH
//   overflow_o     sticky: push attempted while full
//   underflow_o    sticky: pop attempted while empty
module sync_fifo_ctl #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = 14,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] dat_i,
   output logic             full_o,
   output logic             almost_full_o,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dat_o,
   output logic             empty_o,
   output logic             almost_empty_o,
   output logic [DEPTH:0]   count_o,
   output logic             overflow_o,
   output logic             underflow_o
);

   localparam int unsigned ENTRIES = 1 << DEPTH;
   localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(ENTRIES);
   localparam logic [DEPTH:0] AF_CNT   = (DEPTH+1)'(AF_LEVEL);
   localparam logic [DEPTH:0] AE_CNT   = (DEPTH+1)'(AE_LEVEL);

   logic [WIDTH-1:0] mem [ENTRIES];
   logic [DEPTH-1:0] wptr;
   logic [DEPTH-1:0] rptr;
   logic [DEPTH:0]   count;
   logic             ovf;
   logic             udf;
   logic             full;
   logic             empty;
   logic             push_ok;
   logic             pop_ok;

   // Status is decoded from registered count only, so no input reaches an
   // output combinationally.
   always_comb begin
      full    = (count == FULL_CNT);
      empty   = (count == '0);
      push_ok = push_i && !full  && !clr_i;
      pop_ok  = pop_i  && !empty && !clr_i;
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else if (clr_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Flags judge the state before this edge, not the post-pop state.
         if (push_i && full)  ovf <= 1'b1;
         if (pop_i  && empty) udf <= 1'b1;
      end
   end

   // Storage carries no reset; stale contents are masked by empty/count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= dat_i;
   end

   always_comb begin
      dat_o          = empty ? '0 : mem[rptr];
      full_o         = full;
      empty_o        = empty;
      almost_full_o  = (count >= AF_CNT);
      almost_empty_o = (count <= AE_CNT);
      count_o        = count;
      overflow_o     = ovf;
      underflow_o    = udf;
   end

endmodule
